// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order instruction buffer; head entry is always slot 0.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       pop_i,
  output entry_t     head_o,
  output logic [1:0] count_o
);
  entry_t     mem_q [2];
  logic [1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          mem_q[count_q[0]] <= push_data_i;
          count_q           <= count_q + 2'd1;
        end
        2'b01: begin
          mem_q[0] <= mem_q[1];
          count_q  <= count_q - 2'd1;
        end
        2'b11: begin
          // Shift and refill: the new entry lands behind whatever survives the pop.
          if (count_q == 2'd2) begin
            mem_q[0] <= mem_q[1];
            mem_q[1] <= push_data_i;
          end else begin
            mem_q[0] <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_o  = (count_q != 2'd0) ? mem_q[0] : '0;
  assign count_o = count_q;
endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM feeding a 2-entry decode buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] decoder_in,
  output logic [31:0] pc_value
);
  state_e          state_q;
  logic [XLEN-1:0] pc_q, fetch_pc_q, redir_pc;
  logic            accept, push, pop;
  logic [1:0]      buf_count;
  entry_t          head, push_data;

  assign redir_pc       = {redirect_pc[31:2], 2'b00};
  assign imem_req_valid = (state_q == REQ) && (int'(buf_count) < BUF_DEPTH);
  assign imem_addr      = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  // Redirect beats both push and pop: the flush wins and nothing else moves.
  assign push           = (state_q == WAIT) && imem_resp_valid && !redirect_valid;
  assign pop            = inst_valid && inst_ready && !redirect_valid;
  assign push_data      = '{pc: fetch_pc_q, inst: imem_resp_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      if (accept) fetch_pc_q <= pc_q;
      if (redirect_valid) pc_q <= redir_pc;
      else if (accept)    pc_q <= pc_q + PC_STEP;
      unique case (state_q)
        IDLE: state_q <= REQ;
        REQ:  if (accept) state_q <= redirect_valid ? DROP : WAIT;
        WAIT: begin
          if (imem_resp_valid)     state_q <= REQ;
          else if (redirect_valid) state_q <= DROP;
        end
        DROP: if (imem_resp_valid) state_q <= REQ;
        default: state_q <= IDLE;
      endcase
    end
  end

  fetch_buffer u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (buf_count)
  );

  assign inst_valid = (buf_count != 2'd0);
  assign decoder_in = head.inst;
  assign pc_value   = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: random memory/decoder/redirect traffic against a stream-level model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready, imem_resp_valid, redirect_valid;
  logic        inst_valid, inst_ready;
  logic [31:0] imem_addr, imem_resp_data, redirect_pc, decoder_in, pc_value;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .decoder_in(decoder_in), .pc_value(pc_value)
  );

  logic        w_rst_n = 1'b0, w_ready = 1'b0, w_resp = 1'b0, w_req_valid, w_inst_valid;
  logic        w_redir = 1'b0, w_iready = 1'b0;
  logic [31:0] w_addr, w_data = '0, w_rpc = '0, w_dec, w_pc;

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_ready), .imem_addr(w_addr),
    .imem_resp_valid(w_resp), .imem_resp_data(w_data),
    .redirect_valid(w_redir), .redirect_pc(w_rpc),
    .inst_valid(w_inst_valid), .inst_ready(w_iready),
    .decoder_in(w_dec), .pc_value(w_pc)
  );

  int n_chk = 0, n_fail = 0;

  // Model: the decoder sees consecutive words starting at the last redirect target.
  bit          out_v, out_stale;
  int          out_wait, cnt;
  logic [31:0] out_addr, exp_pc, nxt_req, force_tgt;
  logic [31:0] acc_log[$], pop_log[$];
  int          p_ready, p_iready, p_redir, lat_max, redir_mode;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit exp_rv, acc, rsp, rdr, pop, push;
    logic [31:0] tgt, acc_addr;
    @(negedge clk);
    exp_rv = !out_v && cnt < 2;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("imem_addr", imem_addr, nxt_req);
    chk("inst_valid", 32'(inst_valid), 32'(cnt != 0));
    chk("pc_value", pc_value, (cnt != 0) ? exp_pc : 32'h0);
    chk("decoder_in", decoder_in, (cnt != 0) ? mem_word(exp_pc) : 32'h0);
    rsp = out_v && out_wait == 0;
    rdr = 1'b0;
    tgt = $urandom;
    case (redir_mode)
      1: rdr = out_v && !rsp;
      2: rdr = rsp;
      default: rdr = ($urandom_range(99) < 32'(p_redir));
    endcase
    if (redir_mode != 0 && rdr) begin tgt = force_tgt; redir_mode = 0; end
    imem_req_ready  = ($urandom_range(99) < 32'(p_ready));
    inst_ready      = ($urandom_range(99) < 32'(p_iready));
    imem_resp_valid = rsp;
    imem_resp_data  = rsp ? mem_word(out_addr) : $urandom;
    redirect_valid  = rdr;
    redirect_pc     = tgt;
    acc      = exp_rv && imem_req_ready;
    acc_addr = nxt_req;
    push     = rsp && !out_stale && !rdr;
    pop      = cnt != 0 && inst_ready && !rdr;
    if (acc) acc_log.push_back(imem_addr);
    if (pop) pop_log.push_back(pc_value);
    if (rsp) out_v = 1'b0;
    else if (out_v) out_wait--;
    if (out_v && rdr) out_stale = 1'b1;
    if (rdr) begin
      cnt = 0;
      exp_pc = {tgt[31:2], 2'b00};
      nxt_req = exp_pc;
    end else begin
      cnt += int'(push) - int'(pop);
      if (pop) exp_pc += 32'd4;
    end
    if (acc) begin
      out_v = 1'b1; out_stale = rdr; out_addr = acc_addr;
      out_wait = int'($urandom_range(lat_max));
      if (!rdr) nxt_req = acc_addr + 32'd4;
    end
  endtask

  task automatic apply_reset();
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_decoder_in", decoder_in, 32'h0);
    chk("rst_pc_value", pc_value, 32'h0);
    out_v = 1'b0; out_stale = 1'b0; out_wait = 0; cnt = 0;
    exp_pc = RST_PC; nxt_req = RST_PC;
    @(negedge clk);
    rst_n = 1'b1;
    chk("idle_req_valid", 32'(imem_req_valid), 32'h0);
  endtask

  initial begin
    int n0;
    logic [31:0] last;
    redir_mode = 0;
    // Address wrap on an instance starting at the top word.
    @(negedge clk); w_rst_n = 1'b1;
    @(negedge clk);
    chk("wrap_req0_valid", 32'(w_req_valid), 32'h1);
    chk("wrap_req0_addr", w_addr, 32'hFFFF_FFFC);
    w_ready = 1'b1;
    @(negedge clk); w_ready = 1'b0; w_resp = 1'b1; w_data = 32'hCAFE_0001;
    chk("wrap_wait_valid", 32'(w_req_valid), 32'h0);
    @(negedge clk); w_resp = 1'b0;
    chk("wrap_req1_valid", 32'(w_req_valid), 32'h1);
    chk("wrap_req1_addr", w_addr, 32'h0000_0000);
    chk("wrap_head_pc", w_pc, 32'hFFFF_FFFC);

    // Streaming with always-ready memory and decoder.
    p_ready = 100; p_iready = 100; p_redir = 0; lat_max = 0;
    apply_reset();
    acc_log.delete(); pop_log.delete();
    repeat (8) step();
    chk("stream_req0", acc_log[0], 32'h0);
    chk("stream_req1", acc_log[1], 32'h4);
    chk("stream_req2", acc_log[2], 32'h8);
    chk("stream_pop0", pop_log[0], 32'h0);
    chk("stream_pop1", pop_log[1], 32'h4);

    // Decoder stall fills the buffer and blocks requests; one pop frees a slot.
    p_iready = 0;
    repeat (10) step();
    chk("stall_req_valid", 32'(imem_req_valid), 32'h0);
    chk("stall_inst_valid", 32'(inst_valid), 32'h1);
    n0 = acc_log.size();
    last = acc_log[$];
    p_iready = 100; step(); p_iready = 0;
    repeat (4) step();
    chk("resume_count", 32'(acc_log.size()), 32'(n0 + 1));
    chk("resume_addr", acc_log[$], last + 32'd4);

    // Redirect while waiting: stale response dropped, refetch aligned target.
    p_iready = 100; lat_max = 2; redir_mode = 1; force_tgt = 32'h103;
    for (int i = 0; i < 50 && redir_mode != 0; i++) step();
    chk("redir_wait_fired", 32'(redir_mode), 32'h0);
    @(posedge clk); #1;
    chk("redir_flush", 32'(inst_valid), 32'h0);
    n0 = acc_log.size();
    for (int i = 0; i < 20 && acc_log.size() == n0; i++) step();
    chk("redir_wait_addr", acc_log[$], 32'h100);

    // Redirect coincident with a response.
    redir_mode = 2; force_tgt = 32'h2000;
    for (int i = 0; i < 50 && redir_mode != 0; i++) step();
    chk("redir_resp_fired", 32'(redir_mode), 32'h0);
    @(posedge clk); #1;
    chk("redir_resp_valid", 32'(imem_req_valid), 32'h1);
    chk("redir_resp_addr", imem_addr, 32'h2000);
    chk("redir_resp_flush", 32'(inst_valid), 32'h0);

    // Random traffic.
    p_ready = 70; p_iready = 60; p_redir = 4; lat_max = 3;
    repeat (3000) step();

    // Reset while a response is outstanding.
    p_ready = 100; lat_max = 3; p_redir = 0;
    for (int i = 0; i < 20 && !out_v; i++) step();
    chk("mid_wait_outstanding", 32'(out_v), 32'h1);
    #2;
    apply_reset();
    acc_log.delete();
    repeat (3) step();
    chk("restart_addr", acc_log[0], RST_PC);

    p_ready = 60; p_iready = 70; p_redir = 3;
    repeat (1500) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  RESET_PC, 32'h0000_0000, first fetch address after reset
  BUF_DEPTH, 2, instruction buffer entries (fixed at 2)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  imem_req_valid  out  1  fetch request to instruction memory
  imem_req_ready  in  1  memory accepts request
  imem_addr  out  32  fetch address, word aligned
  imem_resp_valid  in  1  read data valid, at least 1 cycle after accept, in order
  imem_resp_data  in  32  instruction word
  redirect_valid  in  1  branch/jump taken, flush and refetch
  redirect_pc  in  32  redirect target
  inst_valid  out  1  decoder_in/pc_value valid for the decoder
  inst_ready  in  1  decoder consumes this cycle
  decoder_in  out  32  instruction to decoder
  pc_value  out  32  PC of decoder_in
REQ-003 Clocking SHALL be one clock (clk); reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-005 IDLE: imem_req_valid=0; SHALL move to REQ on the first clk edge after rst_n deasserts.
REQ-006 REQ: imem_req_valid=1 only when buffer count<2; imem_addr=pc.
REQ-007 Accept (imem_req_valid&imem_req_ready) SHALL set pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) and move to WAIT.
REQ-008 WAIT: imem_resp_valid SHALL push {fetch pc, imem_resp_data} into the buffer and move to REQ; room is guaranteed by REQ-006.
REQ-009 Buffer SHALL be in-order, 2 entries; inst_valid = count!=0; decoder_in/pc_value = head entry; zero when empty.
REQ-010 inst_valid&inst_ready SHALL pop the head; simultaneous push and pop SHALL leave count unchanged.
REQ-011 Latency: response arriving at edge N SHALL appear on inst_valid after edge N (registered, no bypass).
REQ-012 Redirect SHALL flush the buffer (inst_valid=0 next cycle) and set pc<={redirect_pc[31:2],2'b00}.
REQ-013 Redirect in REQ without accept -> stay REQ with new address next cycle; redirect on an accepted request -> DROP.
REQ-014 Redirect in WAIT without resp -> DROP; redirect in WAIT with resp -> response discarded, go REQ.
REQ-015 DROP: imem_req_valid=0; next imem_resp_valid SHALL be discarded, then REQ; redirect in DROP updates pc only.
REQ-016 Redirect SHALL take priority over push and pop in the same cycle.

Reset
REQ-017 While rst_n=0: state IDLE, pc=RESET_PC, buffer empty, imem_req_valid=0, imem_addr=RESET_PC, inst_valid=0, decoder_in=0, pc_value=0.
REQ-018 rst_n assertion mid-request SHALL abandon any outstanding response; the memory side is reset together with the fetch unit.

Structure
REQ-019 Package fetch_pkg SHALL hold: the state enum, XLEN=32, PC_STEP=4, and the {pc, inst} entry typedef.
REQ-020 Sub-module fetch_buffer (2-entry FIFO with flush, push, pop, count) SHALL be instantiated once.

Verification
REQ-021 Reset release, ready=1, 1-cycle responses -> requests at 0x0,0x4,0x8; decoder sees (0x0,I0),(0x4,I1) in order.
REQ-022 inst_ready=0 -> after 2 responses imem_req_valid=0; one pop -> request resumes at next pc.
REQ-023 Redirect to 0x103 in WAIT -> stale response dropped, next imem_addr=0x100, buffer empty.
REQ-024 Redirect coincident with resp_valid in WAIT -> response discarded; next request at target the following cycle.
REQ-025 RESET_PC=0xFFFF_FFFC -> second request address 0x0000_0000.
REQ-026 rst_n low during WAIT -> all outputs at REQ-017 values immediately; fetch restarts at RESET_PC.
